// File: rtl/mad_sched_pkg.sv
// Shared types and helpers for the round-robin multiply-add scheduler.
// No logic of its own; zero latency.
// No flow control here; the arbiter states and the id-width helper live here.
package mad_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requester index width; floors at one bit so a single-bit id is still legal.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mad_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping N-1 -> 0.
// Purely combinational, zero latency.
// No backpressure of its own; the caller decides when the grant is used.
module mad_rr_pick
    import mad_sched_pkg::*;
#(
    parameter  int N    = 4,
    localparam int ID_W = id_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id,
    output logic            any
);

    always_comb begin
        int j;
        grant = '0;
        id    = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                id       = ID_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mad_rr_scheduler.sv
// Shares one multicycle multiply-add (O = A*B + C) between REQ_COUNT requesters, round-robin.
// Latency: accept on edge t gives RSP_VALID after edge t+CYCLE; peak one result per CYCLE+1 clocks.
// Backpressure: REQ_READY stays low while a result waits on RSP_READY. MAD_SCHED_STAT_EN adds STAT_BUSY.
module mad_rr_scheduler
    import mad_sched_pkg::*;
#(
    parameter  int REQ_COUNT  = 4,
    parameter  int CYCLE      = 3,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_W       = id_w(REQ_COUNT)
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [REQ_COUNT-1:0]            REQ_VALID,
    output logic [REQ_COUNT-1:0]            REQ_READY,
    input  logic [REQ_COUNT*DATA_WIDTH-1:0] REQ_A,
    input  logic [REQ_COUNT*DATA_WIDTH-1:0] REQ_B,
    input  logic [REQ_COUNT*DATA_WIDTH-1:0] REQ_C,
    output logic                            RSP_VALID,
    input  logic                            RSP_READY,
    output logic [ID_W-1:0]                 RSP_ID,
    output logic [DATA_WIDTH-1:0]           RSP_DATA
`ifdef MAD_SCHED_STAT_EN
    ,
    output logic [31:0]                     STAT_BUSY
`endif
);

    localparam int CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;

    if (CYCLE < 1) begin : g_bad_cycle
        $error("mad_rr_scheduler: CYCLE must be >= 1");
    end
    if (REQ_COUNT < 2 || REQ_COUNT > 16) begin : g_bad_count
        $error("mad_rr_scheduler: REQ_COUNT must be 2..16");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] c;
    } operand_t;

    state_t                state;
    state_t                state_nxt;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       op_id;
    logic [ID_W-1:0]       pick_id;
    logic [REQ_COUNT-1:0]  pick_grant;
    logic                  pick_any;
    logic                  accept;
    logic                  exec_done;
    logic [CNT_W-1:0]      cnt;
    operand_t              op;
    operand_t              op_nxt;
    logic [DATA_WIDTH-1:0] mad;
    logic [DATA_WIDTH-1:0] a_arr [REQ_COUNT];
    logic [DATA_WIDTH-1:0] b_arr [REQ_COUNT];
    logic [DATA_WIDTH-1:0] c_arr [REQ_COUNT];

    for (genvar g = 0; g < REQ_COUNT; g++) begin : g_unpack
        assign a_arr[g] = REQ_A[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[g] = REQ_B[g*DATA_WIDTH +: DATA_WIDTH];
        assign c_arr[g] = REQ_C[g*DATA_WIDTH +: DATA_WIDTH];
    end

    mad_rr_pick #(
        .N (REQ_COUNT)
    ) u_pick (
        .req   (REQ_VALID),
        .ptr   (ptr),
        .grant (pick_grant),
        .id    (pick_id),
        .any   (pick_any)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A granted requester is always accepted, so accept is simply "picker found someone".
    always_comb begin
        state_nxt = state;
        REQ_READY = '0;
        RSP_VALID = 1'b0;
        accept    = 1'b0;
        exec_done = 1'b0;
        case (state)
            IDLE: begin
                REQ_READY = pick_grant;
                accept    = pick_any;
                if (pick_any) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    exec_done = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) begin
                    REQ_READY = pick_grant;
                    accept    = pick_any;
                    state_nxt = pick_any ? EXEC : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign op_nxt.a = a_arr[pick_id];
    assign op_nxt.b = b_arr[pick_id];
    assign op_nxt.c = c_arr[pick_id];

    // Operands only move on accept, which is what makes the CYCLE-clock multicycle path safe.
    assign mad = op.a * op.b + op.c;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr      <= '0;
            op_id    <= '0;
            op       <= '0;
            cnt      <= '0;
            RSP_ID   <= '0;
            RSP_DATA <= '0;
        end else begin
            if (accept) begin
                op    <= op_nxt;
                op_id <= pick_id;
                ptr   <= (pick_id == ID_W'(REQ_COUNT - 1)) ? '0 : pick_id + ID_W'(1);
                cnt   <= CNT_W'(CYCLE - 1);
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // The response register is held through a back-to-back accept until this op finishes.
            if (exec_done) begin
                RSP_DATA <= mad;
                RSP_ID   <= op_id;
            end
        end
    end

`ifdef MAD_SCHED_STAT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STAT_BUSY <= '0;
        end else if (state != IDLE) begin
            STAT_BUSY <= STAT_BUSY + 32'd1;
        end
    end
`endif

endmodule
